pe_operand_fetch: RTL

//   Reader/driver side of the PE register file: accepts micro-ops, drives rf read addresses, captures operands into a 1-deep output register, and drives rf write port from the result stream.
//   16-entry busy scoreboard blocks RAW/WAW hazards. Sits between PE instruction queue, pe_register_file and PE ALU/MAC.

---
 rtl/pe_operand_fetch_pkg.sv | 26 ++
 rtl/pe_operand_fetch_scoreboard.sv | 65 ++++++
 rtl/pe_operand_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pe_operand_fetch_pkg.sv
// Shared definitions for the PE operand-fetch slice: widths, opcode constants, scoreboard query record.
// The top-level build option PE_OPFETCH_FWD_EN is consumed in pe_operand_fetch.sv.
package pe_operand_fetch_pkg;

  localparam int PE_DATA_WIDTH = 16;
  localparam int PE_RF_DEPTH   = 16;
  localparam int RF_ADDR_W     = 4;
  localparam int PE_OP_W       = 4;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  localparam logic [PE_OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [PE_OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [PE_OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [PE_OP_W-1:0] OP_MUL = 4'h3;
  localparam logic [PE_OP_W-1:0] OP_MAC = 4'h4;

  // Busy state seen by the issue logic for the micro-op currently offered.
  typedef struct packed {
    logic busy_a;
    logic busy_b;
    logic busy_dst;
    logic stray;
  } sb_query_t;

endpackage

// File: rtl/pe_operand_fetch_scoreboard.sv
// Busy scoreboard for the PE register file: one bit per register, set on issue of a
// writing op, cleared on writeback; a simultaneous set and clear of one register leaves it busy.
module pe_scoreboard
  import pe_operand_fetch_pkg::*;
#(
  parameter int RF_DEPTH = PE_RF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  rf_addr_t            set_idx,
  input  logic                clr_en,
  input  rf_addr_t            clr_idx,
  input  rf_addr_t            q_a,
  input  rf_addr_t            q_b,
  input  rf_addr_t            q_dst,
  output sb_query_t           query,
  output logic [RF_DEPTH-1:0] busy_mask
);

  logic [RF_DEPTH-1:0] busy_r;
  logic [RF_DEPTH-1:0] set_vec_s;
  logic [RF_DEPTH-1:0] clr_vec_s;
  logic [RF_DEPTH-1:0] busy_nxt_s;

  // Decode set/clear requests into one-hot vectors and form the next busy state.
  always_comb begin
    set_vec_s = '0;
    clr_vec_s = '0;
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (set_en && (set_idx == RF_ADDR_W'(i))) begin
        set_vec_s[i] = 1'b1;
      end else begin
        set_vec_s[i] = 1'b0;
      end
      if (clr_en && (clr_idx == RF_ADDR_W'(i))) begin
        clr_vec_s[i] = 1'b1;
      end else begin
        clr_vec_s[i] = 1'b0;
      end
    end
    busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Queries use the current state only, so a bit being cleared this cycle still reads busy.
  always_comb begin
    query          = '0;
    query.busy_a   = busy_r[q_a];
    query.busy_b   = busy_r[q_b];
    query.busy_dst = busy_r[q_dst];
    query.stray    = clr_en & ~busy_r[clr_idx];
  end

  assign busy_mask = busy_r;

endmodule

// File: rtl/pe_operand_fetch.sv
// PE operand fetch: issues micro-ops against the register file, holds a 1-deep operand bundle
// and drives the writeback port. Define PE_OPFETCH_FWD_EN to bypass in-flight writeback data.
module pe_operand_fetch
  import pe_operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int RF_DEPTH   = PE_RF_DEPTH,
  parameter int OP_W       = PE_OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_W-1:0]       instr_op,
  input  logic [RF_ADDR_W-1:0]  instr_src_a,
  input  logic [RF_ADDR_W-1:0]  instr_src_b,
  input  logic [RF_ADDR_W-1:0]  instr_dst,
  input  logic                  instr_wb,
  output logic [RF_ADDR_W-1:0]  rf_raddr_a,
  output logic [RF_ADDR_W-1:0]  rf_raddr_b,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [OP_W-1:0]       op_code,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [RF_ADDR_W-1:0]  op_dst,
  output logic                  op_wb,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [RF_ADDR_W-1:0]  res_dst,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  rf_we,
  output logic [RF_ADDR_W-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [RF_DEPTH-1:0]   busy_mask,
  output logic                  err_wb_stray
);

`ifdef PE_OPFETCH_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  sb_query_t             sb_q_s;
  logic                  fwd_a_s;
  logic                  fwd_b_s;
  logic                  fwd_dst_s;
  logic                  hazard_s;
  logic                  ready_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] opnd_a_s;
  logic [DATA_WIDTH-1:0] opnd_b_s;

  logic                  op_valid_r;
  logic [OP_W-1:0]       op_code_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_b_r;
  logic [RF_ADDR_W-1:0]  op_dst_r;
  logic                  op_wb_r;
  logic                  err_wb_stray_r;

  pe_scoreboard #(
    .RF_DEPTH(RF_DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept_s & instr_wb),
    .set_idx  (instr_dst),
    .clr_en   (res_valid),
    .clr_idx  (res_dst),
    .q_a      (instr_src_a),
    .q_b      (instr_src_b),
    .q_dst    (instr_dst),
    .query    (sb_q_s),
    .busy_mask(busy_mask)
  );

  // Hazard detection, optional bypass of the writeback in flight, and operand selection.
  always_comb begin
    fwd_a_s   = FWD_EN & res_valid & (res_dst == instr_src_a);
    fwd_b_s   = FWD_EN & res_valid & (res_dst == instr_src_b);
    fwd_dst_s = FWD_EN & res_valid & (res_dst == instr_dst);
    hazard_s  = (sb_q_s.busy_a & ~fwd_a_s)
              | (sb_q_s.busy_b & ~fwd_b_s)
              | (instr_wb & sb_q_s.busy_dst & ~fwd_dst_s);
    ready_s   = ~hazard_s & (~op_valid_r | op_ready);
    accept_s  = instr_valid & ready_s;
    if (fwd_a_s) begin
      opnd_a_s = res_data;
    end else begin
      opnd_a_s = rf_rdata_a;
    end
    if (fwd_b_s) begin
      opnd_b_s = res_data;
    end else begin
      opnd_b_s = rf_rdata_b;
    end
  end

  // Operand bundle register: load on accept, drop when consumed, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_r <= 1'b0;
      op_code_r  <= '0;
      op_a_r     <= '0;
      op_b_r     <= '0;
      op_dst_r   <= '0;
      op_wb_r    <= 1'b0;
    end else if (accept_s) begin
      op_valid_r <= 1'b1;
      op_code_r  <= instr_op;
      op_a_r     <= opnd_a_s;
      op_b_r     <= opnd_b_s;
      op_dst_r   <= instr_dst;
      op_wb_r    <= instr_wb;
    end else if (op_ready) begin
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= op_valid_r;
    end
  end

  // Sticky flag for a writeback that targets a register nobody marked busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wb_stray_r <= 1'b0;
    end else if (sb_q_s.stray) begin
      err_wb_stray_r <= 1'b1;
    end else begin
      err_wb_stray_r <= err_wb_stray_r;
    end
  end

  assign instr_ready  = ready_s;
  assign rf_raddr_a   = instr_src_a;
  assign rf_raddr_b   = instr_src_b;
  assign op_valid     = op_valid_r;
  assign op_code      = op_code_r;
  assign op_a         = op_a_r;
  assign op_b         = op_b_r;
  assign op_dst       = op_dst_r;
  assign op_wb        = op_wb_r;
  assign res_ready    = 1'b1;
  assign rf_we        = res_valid;
  assign rf_waddr     = res_dst;
  assign rf_wdata     = res_data;
  assign err_wb_stray = err_wb_stray_r;

endmodule
